host_cmd_serializer: RTL and testbench



---
 rtl/host_cmd_serializer.sv | 238 +++++++++++++++++++++++
 tb/tb_host_cmd_serializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_serializer.sv
// Frames host commands (AA/BB/CC/DD packets) and shifts them out LSB-first as UART.
// Optional parity bit per byte when HOST_CMD_SERIALIZER_PARITY_EN is defined.
module host_cmd_serializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int BIT_CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_data,
    input  logic [DATA_WIDTH-1:0]    cmd_opb,
    input  logic [3:0]               cmd_fun,
    input  logic                     par_en,
    input  logic                     par_typ,
    input  logic [BIT_CNT_W-1:0]     bit_period,
    output logic                     tx_line,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_AOP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_ANO = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef HOST_CMD_SERIALIZER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                   state_q;
    logic [1:0]               type_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH-1:0]    opb_q;
    logic [3:0]               fun_q;
    logic [BIT_CNT_W-1:0]     period_q;
    logic [BIT_CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]         bit_q;
    logic [1:0]               idx_q;
    logic [DATA_WIDTH-1:0]    cur_q;
    logic [DATA_WIDTH-1:0]    sh_q;
    logic                     tx_q;
    logic                     done_q;
`ifdef HOST_CMD_SERIALIZER_PARITY_EN
    logic                     par_en_q;
    logic                     par_typ_q;
`else
    logic                     unused_par;
    assign unused_par = par_en ^ par_typ;
`endif

    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input logic [1:0]               typ,
        input logic [1:0]               idx,
        input logic [ADDRESS_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0]    data,
        input logic [DATA_WIDTH-1:0]    opb,
        input logic [3:0]               fun
    );
        logic [DATA_WIDTH-1:0] b;
        b = '0;
        case (typ)
            2'd0: case (idx)
                2'd0:    b = HDR_WR;
                2'd1:    b = DATA_WIDTH'(addr);
                default: b = data;
            endcase
            2'd1: case (idx)
                2'd0:    b = HDR_RD;
                default: b = DATA_WIDTH'(addr);
            endcase
            2'd2: case (idx)
                2'd0:    b = HDR_AOP;
                2'd1:    b = data;
                2'd2:    b = opb;
                default: b = DATA_WIDTH'(fun);
            endcase
            default: case (idx)
                2'd0:    b = HDR_ANO;
                default: b = DATA_WIDTH'(fun);
            endcase
        endcase
        return b;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] typ);
        case (typ)
            2'd0:    return 2'd2;
            2'd2:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    logic                  accept;
    logic [BIT_CNT_W-1:0]  period_d;
    logic [DATA_WIDTH-1:0] next_byte_d;
    logic                  last_d;
    logic                  finish_d;

    assign busy       = (state_q != S_IDLE);
    assign cmd_ready  = !busy && !reset;
    assign accept     = cmd_valid && cmd_ready;
    assign tx_line    = tx_q;
    assign frame_done = done_q;
    assign period_d   = (bit_period == '0) ? BIT_CNT_W'(1) : bit_period;
    assign last_d     = (idx_q == last_idx(type_q));
    assign next_byte_d = frame_byte(type_q, idx_q + 2'd1, addr_q,
                                    data_q, opb_q, fun_q);
    // Last cycle of the final stop bit is spent in IDLE so a new frame can follow gap-free.
    assign finish_d   = last_d && (period_q == BIT_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            opb_q     <= '0;
            fun_q     <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            cur_q     <= '0;
            sh_q      <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef HOST_CMD_SERIALIZER_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        type_q    <= cmd_type;
                        addr_q    <= cmd_addr;
                        data_q    <= cmd_data;
                        opb_q     <= cmd_opb;
                        fun_q     <= cmd_fun;
                        period_q  <= period_d;
                        cnt_q     <= period_d - BIT_CNT_W'(1);
                        idx_q     <= 2'd0;
                        cur_q     <= frame_byte(cmd_type, 2'd0, cmd_addr,
                                                cmd_data, cmd_opb, cmd_fun);
`ifdef HOST_CMD_SERIALIZER_PARITY_EN
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
`endif
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DATA;
                        tx_q    <= cur_q[0];
                        sh_q    <= cur_q >> 1;
                        bit_q   <= '0;
                        cnt_q   <= period_q - BIT_CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q - BIT_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - BIT_CNT_W'(1);
                    end else if (bit_q != BIT_W'(DATA_WIDTH - 1)) begin
                        bit_q <= bit_q + BIT_W'(1);
                        tx_q  <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                        cnt_q <= period_q - BIT_CNT_W'(1);
`ifdef HOST_CMD_SERIALIZER_PARITY_EN
                    end else if (par_en_q) begin
                        state_q <= S_PARITY;
                        tx_q    <= (^cur_q) ^ par_typ_q;
                        cnt_q   <= period_q - BIT_CNT_W'(1);
`endif
                    end else if (finish_d) begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        cnt_q   <= period_q - BIT_CNT_W'(1);
                    end
                end
`ifdef HOST_CMD_SERIALIZER_PARITY_EN
                S_PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - BIT_CNT_W'(1);
                    end else if (finish_d) begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        cnt_q   <= period_q - BIT_CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (last_d && cnt_q == BIT_CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        idx_q   <= idx_q + 2'd1;
                        cur_q   <= next_byte_d;
                        cnt_q   <= period_q - BIT_CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q - BIT_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_host_cmd_serializer.sv
// Directed bench for host_cmd_serializer: decodes tx_line bit by bit per frame.
module tb_host_cmd_serializer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic [7:0]  cmd_opb = '0;
    logic [3:0]  cmd_fun = '0;
    logic        par_en = 1'b0;
    logic        par_typ = 1'b0;
    logic [15:0] bit_period = 16'd1;
    logic        tx_line;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    host_cmd_serializer #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .BIT_CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
        .par_en(par_en), .par_typ(par_typ), .bit_period(bit_period),
        .tx_line(tx_line), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the offer until the block accepts it; return one sample after the accept edge.
    task automatic send(input string tag);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 1000) begin
            step();
            t++;
        end
        chk({tag, "_accept_wait"}, 32'(t < 1000), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Capture the frame starting at the current sample until frame_done.
    task automatic run_frame(input string tag, input int nb,
                             input logic [31:0] bytes, input logic [3:0] pbits,
                             input bit pen, input int P);
        logic       cap [0:511];
        int         idx, bits, L, busy_bad, unstable;
        logic [10:0] ev, av;
        bits = 10;
`ifdef HOST_CMD_SERIALIZER_PARITY_EN
        if (pen) bits = 11;
`endif
        L = nb * bits * P;
        idx = 0;
        busy_bad = 0;
        while (idx < 500) begin
            cap[idx] = tx_line;
            if (frame_done) break;
            if (!busy) busy_bad++;
            step();
            idx++;
        end
        chk({tag, "_len"}, 32'(idx + 1), 32'(L));
        chk({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
        chk({tag, "_ready_at_done"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        for (int b = 0; b < nb; b++) begin
            ev = '0;
            av = '0;
            ev[8:1] = bytes[8*b +: 8];
            ev[bits-1] = 1'b1;
            if (bits == 11) ev[9] = pbits[b];
            for (int j = 0; j < bits; j++) av[j] = cap[(b * bits + j) * P];
            chk($sformatf("%s_byte%0d", tag, b), 32'(av), 32'(ev));
        end
        unstable = 0;
        for (int i = 0; i < L && i <= idx; i++)
            if (cap[i] !== cap[(i / P) * P]) unstable++;
        chk({tag, "_bit_stable"}, 32'(unstable), 32'd0);
    endtask

    initial begin
        int dn;
        int low;
        // reset state
        repeat (3) step();
        chk("rst_tx", 32'(tx_line), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", 32'(cmd_ready), 32'd1);
        step();

        // write addr 5 data 3C, 4 cycles per bit; inputs scrambled after accept
        cmd_type = 2'd0; cmd_addr = 4'd5; cmd_data = 8'h3C;
        par_en = 1'b0; par_typ = 1'b0; bit_period = 16'd4;
        send("wr");
        cmd_data = 8'hFF; cmd_addr = 4'hF; bit_period = 16'd7;
        par_en = 1'b1; cmd_type = 2'd3;
        cmd_valid = 1'b1;
        run_frame("wr", 3, {8'h00, 8'h3C, 8'h05, 8'hAA}, 4'b0000, 1'b0, 4);
        cmd_valid = 1'b0;
        step();
        chk("wr_done_pulse", 32'(frame_done), 32'd0);
        chk("wr_idle_tx", 32'(tx_line), 32'd1);
        step();

        // read addr 2 even parity, then type 3 offered in the frame_done cycle
        cmd_type = 2'd1; cmd_addr = 4'd2; cmd_data = 8'h00;
        par_en = 1'b1; par_typ = 1'b0; bit_period = 16'd2;
        send("rd");
        run_frame("rd", 2, {16'h0, 8'h02, 8'hBB}, 4'b0010, 1'b1, 2);
        cmd_type = 2'd3; cmd_fun = 4'hA; par_en = 1'b0; bit_period = 16'd1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("b2b_start_now", 32'(tx_line), 32'd0);
        run_frame("alu_noop", 2, {16'h0, 8'h0A, 8'hDD}, 4'b0000, 1'b0, 1);
        step();
        chk("alu_noop_done_pulse", 32'(frame_done), 32'd0);

        // type 2 with odd parity
        cmd_type = 2'd2; cmd_data = 8'h12; cmd_opb = 8'h34; cmd_fun = 4'd3;
        par_en = 1'b1; par_typ = 1'b1; bit_period = 16'd3;
        send("alu_op");
        run_frame("alu_op", 4, {8'h03, 8'h34, 8'h12, 8'hCC}, 4'b1011, 1'b1, 3);
        step();

        // bit_period 0 behaves as 1
        cmd_type = 2'd0; cmd_addr = 4'd0; cmd_data = 8'hFF;
        par_en = 1'b0; bit_period = 16'd0;
        send("bp0");
        run_frame("bp0", 3, {8'h00, 8'hFF, 8'h00, 8'hAA}, 4'b0000, 1'b0, 1);
        step();

        // reset in the middle of a write frame
        cmd_type = 2'd0; cmd_addr = 4'd5; cmd_data = 8'h3C;
        par_en = 1'b0; bit_period = 16'd4;
        send("rstmid");
        repeat (49) step();
        reset = 1'b1;
        step();
        chk("rstmid_tx", 32'(tx_line), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        #1;
        chk("rstmid_ready", 32'(cmd_ready), 32'd1);
        dn = 0;
        low = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (frame_done) dn++;
            if (!tx_line) low++;
        end
        chk("rstmid_no_done", 32'(dn), 32'd0);
        chk("rstmid_line_idle", 32'(low), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
